vga_timing_gen: RTL

//  Source end of the VGA timing bus: generates hcount/vcount, hsync/vsync and hblnk/vblnk
//  for 800x600@60 Hz on clk40 (40 MHz). Feeds every screen renderer (start/game/end) in

---
 rtl/vga_timing_gen.sv | 105 ++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 800x600@60 VGA counters, syncs, blanking and line/frame strobes.
// Define VGA_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen #(
    parameter int   H_VIS    = 800,
    parameter int   H_FP     = 40,
    parameter int   H_SYNC   = 128,
    parameter int   H_BP     = 88,
    parameter int   V_VIS    = 600,
    parameter int   V_FP     = 1,
    parameter int   V_SYNC   = 4,
    parameter int   V_BP     = 23,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic        clk40,
    input  logic        rst_n,
    input  logic        enable,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic        line_start,
    output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam logic [10:0] H_END  = 11'(H_TOT - 1);
    localparam logic [10:0] V_END  = 11'(V_TOT - 1);
    localparam logic [10:0] HS_ON  = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_OFF = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [10:0] VS_ON  = 11'(V_VIS + V_FP);
    localparam logic [10:0] VS_OFF = 11'(V_VIS + V_FP + V_SYNC);
    localparam logic [10:0] HB_ON  = 11'(H_VIS);
    localparam logic [10:0] VB_ON  = 11'(V_VIS);

    if (H_TOT > 2048 || V_TOT > 2048) begin : g_size_chk
        $error("vga_timing_gen: H_TOT and V_TOT must not exceed 2048");
    end

    logic [10:0] h_q, h_d, v_q, v_d;
    logic        hs_q, hs_d, vs_q, vs_d, hb_q, hb_d, vb_q, vb_d, ls_q, ls_d, fs_q, fs_d;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] fc_q, fc_d;
`endif

    // Flags are decoded from the next counter values so they land with the counters.
    always_comb begin
        h_d  = !enable ? h_q : (h_q == H_END) ? '0 : h_q + 11'd1;
        v_d  = (!enable || h_q != H_END) ? v_q : (v_q == V_END) ? '0 : v_q + 11'd1;
        hs_d = (h_d >= HS_ON && h_d < HS_OFF) ? SYNC_POL : ~SYNC_POL;
        vs_d = (v_d >= VS_ON && v_d < VS_OFF) ? SYNC_POL : ~SYNC_POL;
        hb_d = h_d >= HB_ON;
        vb_d = v_d >= VB_ON;
        ls_d = enable ? (h_q == H_END) : ls_q;
        fs_d = enable ? (h_q == H_END && v_q == V_END) : fs_q;
`ifdef VGA_FRAME_CNT_EN
        fc_d = (fs_d && !fs_q) ? fc_q + 16'd1 : fc_q;
`endif
    end

    always_ff @(posedge clk40 or negedge rst_n) begin
        if (!rst_n) begin
            h_q  <= '0;
            v_q  <= '0;
            hs_q <= ~SYNC_POL;
            vs_q <= ~SYNC_POL;
            hb_q <= 1'b0;
            vb_q <= 1'b0;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            hb_q <= hb_d;
            vb_q <= vb_d;
            ls_q <= ls_d;
            fs_q <= fs_d;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge clk40 or negedge rst_n) begin
        if (!rst_n) fc_q <= '0;
        else        fc_q <= fc_d;
    end

    assign frame_cnt = fc_q;
`endif

    assign hcount_out  = h_q;
    assign vcount_out  = v_q;
    assign hsync_out   = hs_q;
    assign vsync_out   = vs_q;
    assign hblnk_out   = hb_q;
    assign vblnk_out   = vb_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
endmodule
